// File: rtl/div.sv
// rtl/div.sv - sequential signed radix-2 restoring divider (MIPS DIV semantics)
//
// Purpose: computes srcA / srcB on two's complement operands, one quotient bit
// per clock. The quotient goes to lo and the remainder to hi. A start request is
// accepted in IDLE only. Results are valid, with a one-cycle done pulse, N+1
// edges after the start edge.
//
// Ports:
//   clk      in   1  rising-edge clock
//   reset    in   1  asynchronous active-low reset
//   srcA     in   N  dividend, sampled on the start edge
//   srcB     in   N  divisor, sampled on the start edge
//   divCtrl  in   1  start request, honoured only in IDLE
//   hi       out  N  remainder of the last completed division
//   lo       out  N  quotient of the last completed division
//   busy     out  1  division in progress (DIVIDE or FINISH)
//   done     out  1  one-cycle pulse on result update or divide-by-zero report
//   divZero  out  1  last accepted start had srcB == 0

module div #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] srcA,
  input  logic [N-1:0] srcB,
  input  logic         divCtrl,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         divZero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

  state_t         state, state_next;
  logic [N-1:0]   divisor;
  logic [N-1:0]   quot;      // holds the dividend; quotient bits shift in from the right
  logic [N:0]     rem;       // one spare bit so the trial subtraction sign is visible
  logic [CW-1:0]  count;
  logic           q_neg;
  logic           r_neg;

  logic           start_req;
  logic           start_zero;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [N:0]     shifted;
  logic [N:0]     trial;

  assign start_req  = (state == IDLE) && divCtrl;
  assign start_zero = (srcB == '0);

  // Magnitudes as unsigned N-bit values; the most negative input maps to 2^(N-1).
  assign a_mag = srcA[N-1] ? -srcA : srcA;
  assign b_mag = srcB[N-1] ? -srcB : srcB;

  assign shifted = {rem[N-1:0], quot[N-1]};
  assign trial   = shifted - {1'b0, divisor};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_req && !start_zero) begin
          state_next = DIVIDE;
        end
      end
      DIVIDE: begin
        if (count == CW'(1)) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divisor <= '0;
      quot    <= '0;
      rem     <= '0;
      count   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req) begin
            if (start_zero) begin
              // Report immediately; hi/lo keep the previous result.
              divZero <= 1'b1;
              done    <= 1'b1;
            end else begin
              quot    <= a_mag;
              divisor <= b_mag;
              q_neg   <= srcA[N-1] ^ srcB[N-1];
              r_neg   <= srcA[N-1];
              rem     <= '0;
              count   <= CW'(N);
              divZero <= 1'b0;
            end
          end
        end
        DIVIDE: begin
          if (!trial[N]) begin
            rem  <= trial;
            quot <= {quot[N-2:0], 1'b1};
          end else begin
            rem  <= shifted;
            quot <= {quot[N-2:0], 1'b0};
          end
          count <= count - CW'(1);
        end
        FINISH: begin
          // Remainder magnitude is below the divisor, so the low N bits hold it exactly.
          lo   <= q_neg ? -quot : quot;
          hi   <= r_neg ? -rem[N-1:0] : rem[N-1:0];
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Sequential signed integer divider; the inverse companion to the shift-add `mult` unit in the ALU/execute datapath.
- Computes srcA / srcB with MIPS DIV semantics: quotient to `lo`, remainder to `hi`.
- Radix-2 restoring algorithm, one quotient bit per clock.
- Start-pulse/done-pulse handshake, mirroring the multiplier's control style.

Parameters:
- N, 32, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- srcA  input  N  dividend, two's complement; sampled on the start edge only.
- srcB  input  N  divisor, two's complement; sampled on the start edge only.
- divCtrl  input  1  start request; sampled high on a rising edge while in IDLE.
- hi  output  N  remainder of the last completed division.
- lo  output  N  quotient of the last completed division.
- busy  output  1  high while a division is in progress (DIVIDE or FINISH).
- done  output  1  one-cycle pulse when hi/lo are updated, or a divide-by-zero is reported.
- divZero  output  1  high if the last started operation had srcB == 0; held until the next accepted start.

Behaviour:
- Reset (reset == 0, asynchronous):
  - hi, lo, busy, done, divZero and all internal registers go to 0; state goes to IDLE.
  - Applies immediately, including mid-division; the in-flight result is discarded.
- States: IDLE, DIVIDE, FINISH.
- IDLE, divCtrl == 1 at edge k, srcB != 0:
  - Latch |srcA| and |srcB| (N-bit unsigned magnitudes; |0x80..0| = 2^(N-1)).
  - Latch quotient sign = sign(A) XOR sign(B) and remainder sign = sign(A).
  - Clear the partial remainder (N+1 bits); load counter = N; clear divZero; busy = 1; go to DIVIDE.
- IDLE, divCtrl == 1 at edge k, srcB == 0:
  - divZero = 1 and done = 1 for the cycle after edge k; hi and lo unchanged; stay in IDLE; busy stays 0.
- DIVIDE, each edge:
  - Shift {remainder, dividend} left by one.
  - Trial-subtract the divisor from the remainder; if non-negative, keep the difference and shift in a quotient bit of 1, otherwise restore and shift in 0.
  - Decrement the counter.
  - After the N-th step (edge k+N), go to FINISH.
- FINISH, edge k+N+1:
  - lo = quotient, negated if the quotient sign is set.
  - hi = remainder, negated if the remainder sign is set.
  - done = 1 for exactly one cycle; busy = 0; return to IDLE.
- Latency: start at edge k -> hi/lo valid and done high after edge k+N+1 (N+2 cycles inclusive).
- hi/lo hold their value between completions and during a new division.
- Rounding: the quotient truncates toward zero. The remainder has the sign of the dividend, or is 0. The identity A = lo*B + hi holds modulo 2^N.
- Overflow: 0x80..0 / -1 gives lo = 0x80..0, hi = 0. No flag is raised.
- divCtrl while busy is ignored, with no queuing. divCtrl held high through IDLE starts a new division on the first IDLE edge, i.e. back-to-back operation.
- Operand changes after the start edge do not affect the result.
- done and busy are never high in the same cycle, except that done and busy are both 0 in IDLE.

Test Plan:
- Basic unsigned: srcA = 780, srcB = 30, pulse divCtrl 1 cycle -> after N+2 cycles lo = 26, hi = 0, done pulses once, divZero = 0.
- Signed combinations:
  - -100/7 -> lo = 0xFFFFFFF2 (-14), hi = 0xFFFFFFFE (-2).
  - 100/-7 -> lo = -14, hi = 2.
  - -100/-7 -> lo = 14, hi = -2.
  - 7/100 -> lo = 0, hi = 7.
- Divide by zero: previous result lo = 26, hi = 0; start with srcB = 0 -> done one cycle after the start edge, divZero = 1, busy never high, hi/lo still 26/0. Next valid start clears divZero.
- Overflow: srcA = 0x80000000, srcB = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- Start during busy / operand change: start 780/30, re-pulse divCtrl with 50/5 at cycle 5 and change srcA to 0 -> result remains lo = 26, hi = 0 with a single done; no second done.
- Reset mid-operation: start 780/30, drive reset = 0 asynchronously mid-cycle at cycle 10 -> hi, lo, busy, done, divZero = 0 immediately. After release, a fresh start of 90/9 gives lo = 10, hi = 0 at the normal latency.
